div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle integer divide sequencer for the EX stage. It accepts DIV/DIVU operands from EX over a start/ready handshake and runs a restoring divider, one quotient bit per cycle. It returns {remainder, quotient} for the HI/LO write, and supports pipeline annul (flush) mid-operation. EX holds its stall request for the whole time `start_i` is high and `ready_o` is low.

## Interface
- `DATA_W`, default 32: operand width. Result is 2*DATA_W. Count width is clog2(DATA_W)+1.
- Ports: all are sampled on the rising edge of `clk` unless stated otherwise.
  - `clk` in 1: clock.
  - `rst` in 1: reset, synchronous, active-high.
  - `start_i` in 1: divide request. EX holds it high until it sees `ready_o`.
  - `annul_i` in 1: flush. Aborts any operation in progress.
  - `signed_i` in 1: 1 = DIV (two's complement), 0 = DIVU.
  - `opdata1_i` in DATA_W: dividend. Sampled only on acceptance.
  - `opdata2_i` in DATA_W: divisor. Sampled only on acceptance.
  - `result_o` out 2*DATA_W: {remainder, quotient}. Registered; maps to {HI, LO}.
  - `ready_o` out 1: result valid. High exactly while the FSM is in END.
  - `busy_o` out 1: high in DBZ and ON.

## Operation
- FSM states: IDLE, DBZ, ON, END.
- IDLE:
  - `start_i`=1 and `annul_i`=0 → latch operands and `signed_i`.
  - Divisor = 0 → go to DBZ. Otherwise → go to ON with cnt = 0.
  - `annul_i`=1 blocks acceptance.
- DBZ: on the next edge, `result_o` becomes 0 and the FSM goes to END.
- ON, each cycle, when `annul_i`=0:
  - Shift the partial remainder left by one and bring in the next dividend bit, MSB first.
  - Trial-subtract the divisor. If the difference is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the quotient bit to 0.
  - cnt++. When cnt = DATA_W−1 at the edge, apply the sign fixup, load `result_o`, and go to END.
- Signed operands and sign fixup:
  - Signed mode takes the absolute value of each negative operand (two's complement negate) at acceptance.
  - Quotient is negated iff the operand signs differ.
  - Remainder is negated iff the dividend was negative.
  - Unsigned mode uses the raw operands.
- Overflow case: signed 0x80000000 / −1 wraps to quotient 0x80000000, remainder 0. This is not flagged.
- END:
  - `ready_o`=1 and `result_o` is stable.
  - `start_i`=0 or `annul_i`=1 → go to IDLE on the next edge.
  - `start_i` still high → stay in END. The divider never restarts without first returning to IDLE.
- `annul_i` in DBZ or ON → go to IDLE on the next edge. `result_o` is not updated and `ready_o` never asserts.
- `result_o` holds its last value in every state except at a completing edge.
- `opdata*_i` changes after acceptance are ignored.

## Timing
- Reset (`rst`=1 at an edge): FSM → IDLE, cnt = 0, `result_o` = 0, `ready_o` = 0, `busy_o` = 0. Reset mid-operation behaves the same way; no partial result is kept.
- Start accepted at edge k.
- Nonzero divisor: ON during cycles k+1 … k+DATA_W. `ready_o` is high from cycle k+DATA_W+1, which is k+33 for DATA_W = 32.
- Zero divisor: DBZ in cycle k+1, `ready_o` high from cycle k+2.
- `ready_o` falls one cycle after `start_i` is sampled low in END.
- Back-to-back divides: a new start is accepted no earlier than the edge after END→IDLE.
- `rst` has priority over `annul_i`, and `annul_i` has priority over `start_i`, at every edge.

## Structure
- The shared header/package (alongside macro.v) holds:
  - State encodings DIV_IDLE, DIV_DBZ, DIV_ON, DIV_END.
  - DIVSTART / DIVSTOP.
  - DIVRESULTREADY / DIVRESULTNOTREADY.
  - DOUBLEREGBUS.
- The block is a single flat module with no sub-module. The shift-subtract step is a small combinational expression inside `div_seq`.

## Test plan
- Unsigned divide: DIVU 100/7, start held → `ready_o` rises at k+33 with `result_o` = 0x00000002_0000000E. Then drop start → `ready_o` = 0 in the next cycle.
- Signed divide: DIV −7/2 (0xFFFFFFF9 / 0x00000002) → `result_o` = 0xFFFFFFFF_FFFFFFFD. Also DIV 7/−2 → 0x00000001_FFFFFFFD.
- Divide by zero: 0x1234/0 with start held → `ready_o` at k+2, `result_o` = 0, `busy_o` high only in k+1.
- Annul mid-run: `annul_i` pulsed at cnt = 10 → IDLE next cycle, `ready_o` stays 0, `result_o` unchanged. A fresh 100/7 then completes in 33 cycles.
- Signed overflow and unsigned large operands: DIV 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000. DIVU 0xFFFFFFFF/0x10 → 0x0000000F_0FFFFFFF.
- Reset during ON, and start held across END: `rst` during ON → all outputs 0 next cycle. Start held 5 extra cycles after ready → `ready_o` stays high, `result_o` stable, no restart.

Source files
------------

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared constants for the sequential divider.
//   state_e             - FSM encoding (DIV_IDLE, DIV_DBZ, DIV_ON, DIV_END)
//   DIVSTART/DIVSTOP    - levels of the start request
//   DIVRESULTREADY/...  - levels of the ready flag
//   DOUBLEREGBUS        - width of the {HI, LO} result bus for 32-bit operands
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_DBZ  = 2'b01,
    DIV_ON   = 2'b10,
    DIV_END  = 2'b11
  } state_e;

  localparam logic DIVSTART          = 1'b1;
  localparam logic DIVSTOP           = 1'b0;
  localparam logic DIVRESULTREADY    = 1'b1;
  localparam logic DIVRESULTNOTREADY = 1'b0;

  localparam int unsigned DOUBLEREGBUS = 64;

  // The divider is busy while it owns the datapath and has no result yet.
  function automatic logic is_busy(state_e st);
    return (st == DIV_DBZ) || (st == DIV_ON);
  endfunction

endpackage

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for the EX stage, one quotient bit per cycle.
//   clk, rst    - clock, synchronous active-high reset
//   start_i     - divide request, held by EX until ready_o
//   annul_i     - flush, aborts any operation in progress
//   signed_i    - 1: DIV (two's complement), 0: DIVU
//   opdata1_i   - dividend, sampled on acceptance only
//   opdata2_i   - divisor, sampled on acceptance only
//   result_o    - {remainder, quotient}, registered ({HI, LO})
//   ready_o     - result valid, high exactly while in DIV_END
//   busy_o      - high in DIV_DBZ and DIV_ON
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DOUBLEREGBUS / 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                busy_o
);

  localparam int unsigned     CntW    = $clog2(DATA_W) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  // Holds the remaining dividend bits; quotient bits shift in from the LSB.
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                neg_quot_q, neg_quot_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;

  // Operand magnitudes at acceptance.
  logic              op1_neg, op2_neg;
  logic [DATA_W-1:0] op1_abs, op2_abs;

  assign op1_neg = signed_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_i & opdata2_i[DATA_W-1];
  assign op1_abs = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_abs = op2_neg ? -opdata2_i : opdata2_i;

  // One restoring step. The remainder is always below the divisor, so the
  // shifted value fits DATA_W+1 bits and the restored value fits DATA_W bits.
  logic [DATA_W:0]   shifted, trial;
  logic              q_bit;
  logic [DATA_W-1:0] rem_step, quot_step, rem_fix, quot_fix;

  assign shifted   = {rem_q, dvd_q[DATA_W-1]};
  assign trial     = shifted - {1'b0, dvs_q};
  assign q_bit     = ~trial[DATA_W];
  assign rem_step  = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign quot_step = {dvd_q[DATA_W-2:0], q_bit};

  // Sign fixup. The 0x80..0 / -1 case wraps naturally to 0x80..0.
  assign quot_fix = neg_quot_q ? -quot_step : quot_step;
  assign rem_fix  = neg_rem_q  ? -rem_step  : rem_step;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;

    unique case (state_q)
      DIV_IDLE: begin
        if ((start_i == DIVSTART) && !annul_i) begin
          dvd_d      = op1_abs;
          dvs_d      = op2_abs;
          rem_d      = '0;
          cnt_d      = '0;
          neg_quot_d = op1_neg ^ op2_neg;
          neg_rem_d  = op1_neg;
          state_d    = (opdata2_i == '0) ? DIV_DBZ : DIV_ON;
        end
      end
      DIV_DBZ: begin
        if (annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          result_d = '0;
          state_d  = DIV_END;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = rem_step;
          dvd_d = quot_step;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            result_d = {rem_fix, quot_fix};
            state_d  = DIV_END;
          end
        end
      end
      DIV_END: begin
        if ((start_i == DIVSTOP) || annul_i) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = (state_q == DIV_END) ? DIVRESULTREADY : DIVRESULTNOTREADY;
  assign busy_o   = is_busy(state_q);

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed, table-driven bench for div_seq (DATA_W = 32).
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  div_seq #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  // Called just after a negedge; the following posedge is the acceptance edge.
  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    start_i   = 1'b1;
  endtask

  // Returns the cycle index (acceptance edge = k, first cycle after = 1) at
  // which ready_o is first seen, or -1 on timeout. Operands are scrambled
  // right after acceptance to show they are no longer sampled.
  task automatic wait_ready(output int lat, output logic busy_ok);
    busy_ok = 1'b1;
    @(negedge clk);
    lat = 1;
    opdata1_i = ~opdata1_i;
    opdata2_i = 32'h0000_0003;
    while (!ready_o && lat < 100) begin
      if (!busy_o) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!ready_o) lat = -1;
  endtask

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          lat;
    logic        busy_ok;
    logic        flag;
    logic [63:0] prev;

    vecs[0] = '{"divu_100_7",   1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33};
    vecs[1] = '{"div_m7_2",     1'b1, 32'hFFFFFFF9,  32'h00000002,  64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[2] = '{"div_7_m2",     1'b1, 32'h00000007,  32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33};
    vecs[3] = '{"div_ovf",      1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33};
    vecs[4] = '{"divu_big",     1'b0, 32'hFFFFFFFF,  32'h00000010,  64'h0000000F_0FFFFFFF, 33};
    vecs[5] = '{"divu_dbz",     1'b0, 32'h00001234,  32'h00000000,  64'h00000000_00000000, 2};
    vecs[6] = '{"div_m100_m7",  1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  64'hFFFFFFFE_0000000E, 33};
    vecs[7] = '{"divu_5_9",     1'b0, 32'd5,         32'd9,         64'h00000005_00000000, 33};

    rst       = 1'b1;
    start_i   = 1'b0;
    annul_i   = 1'b0;
    signed_i  = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    repeat (2) @(negedge clk);
    check("reset_result", result_o, 64'h0);
    check("reset_ready", {63'h0, ready_o}, 64'h0);
    check("reset_busy", {63'h0, busy_o}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Table: run each vector with start held, then release.
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_ready(lat, busy_ok);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
      check({vecs[i].name, "_busy_during"}, {63'h0, busy_ok}, 64'h1);
      check({vecs[i].name, "_result"}, result_o, vecs[i].exp);
      check({vecs[i].name, "_busy_at_ready"}, {63'h0, busy_o}, 64'h0);
      start_i = 1'b0;
      @(negedge clk);
      check({vecs[i].name, "_ready_drop"}, {63'h0, ready_o}, 64'h0);
      check({vecs[i].name, "_result_hold"}, result_o, vecs[i].exp);
    end

    // Start held across END for 5 extra cycles: no restart, result stable.
    start_op(1'b0, 32'd1000, 32'd10);
    wait_ready(lat, busy_ok);
    check("hold_result", result_o, 64'h00000000_00000064);
    flag = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!ready_o || busy_o || result_o !== 64'h00000000_00000064) flag = 1'b0;
    end
    check("hold_stable", {63'h0, flag}, 64'h1);
    start_i = 1'b0;
    @(negedge clk);
    check("hold_release", {63'h0, ready_o}, 64'h0);

    // Annul at cnt = 10 (cycle k+11).
    prev = result_o;
    start_op(1'b0, 32'd100, 32'd7);
    repeat (11) @(negedge clk);
    check("annul_busy_before", {63'h0, busy_o}, 64'h1);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_busy", {63'h0, busy_o}, 64'h0);
    check("annul_result", result_o, prev);
    flag = 1'b1;
    repeat (4) begin
      if (ready_o || busy_o) flag = 1'b0;
      @(negedge clk);
    end
    check("annul_no_ready", {63'h0, flag}, 64'h1);
    start_op(1'b0, 32'd100, 32'd7);
    wait_ready(lat, busy_ok);
    check("after_annul_latency", 64'(lat), 64'd33);
    check("after_annul_result", result_o, 64'h00000002_0000000E);
    start_i = 1'b0;
    @(negedge clk);

    // Annul in DBZ: no result write, no ready.
    prev = result_o;
    start_op(1'b0, 32'h55, 32'h0);
    @(negedge clk);
    check("dbz_annul_busy_before", {63'h0, busy_o}, 64'h1);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("dbz_annul_ready", {63'h0, ready_o}, 64'h0);
    check("dbz_annul_result", result_o, prev);
    @(negedge clk);
    check("dbz_annul_idle", {63'h0, busy_o | ready_o}, 64'h0);

    // Annul in END with start still high: back to IDLE, and annul blocks acceptance.
    start_op(1'b0, 32'd9, 32'd3);
    wait_ready(lat, busy_ok);
    check("end_annul_result", result_o, 64'h00000000_00000003);
    annul_i = 1'b1;
    @(negedge clk);
    check("end_annul_ready", {63'h0, ready_o}, 64'h0);
    @(negedge clk);
    check("annul_blocks_start", {63'h0, busy_o}, 64'h0);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);

    // Reset during ON clears everything.
    start_op(1'b0, 32'd100, 32'd7);
    repeat (6) @(negedge clk);
    check("rst_on_busy_before", {63'h0, busy_o}, 64'h1);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_on_result", result_o, 64'h0);
    check("rst_on_ready", {63'h0, ready_o}, 64'h0);
    check("rst_on_busy", {63'h0, busy_o}, 64'h0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
